// File: rtl/uab_board_io.sv
// Board I/O peripheral: software LEDs plus debounced keys with sticky press capture and a maskable irq.
// Define UAB_BOARD_IO_LED_PWM_EN to add an 8-bit PWM brightness register at word address 4.
module uab_board_io #(
  parameter int                N_LEDS          = 8,
  parameter int                N_KEYS          = 2,
  parameter int                DEBOUNCE_CYCLES = 500000,
  parameter int                KEY_ACTIVE_LOW  = 1,
  parameter logic [N_LEDS-1:0] LED_RESET_VAL   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              readdatavalid,
  output logic              irq,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_LEDS-1:0] led_out
);

  localparam int                CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]     DB_TC    = CW'(DEBOUNCE_CYCLES);
  localparam logic [N_KEYS-1:0] SYNC_RST = (KEY_ACTIVE_LOW != 0) ? '1 : '0;

  logic [N_KEYS-1:0] r_sync1, r_sync2, r_state, r_edge, r_mask;
  logic [CW-1:0]     r_cnt [N_KEYS];
  logic [N_LEDS-1:0] r_led, r_led_out;
  logic [31:0]       r_readdata;
  logic              r_rvalid, r_irq;

  logic [N_KEYS-1:0] w_level, w_accept, w_rise, w_w1c;
  logic [N_LEDS-1:0] w_led_on;
  logic [31:0]       w_rdata;
  logic              w_unused;

  assign w_unused = &{1'b0, writedata};
  assign w_level  = (KEY_ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
  assign w_rise   = w_accept & w_level;
  assign w_w1c    = (write && address == 3'd2) ? writedata[N_KEYS-1:0] : '0;

  // A key change is accepted on the cycle the disagreement count would reach the terminal value.
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < N_KEYS; i++)
      w_accept[i] = (w_level[i] != r_state[i]) && ((r_cnt[i] + CW'(1)) == DB_TC);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= SYNC_RST;
      r_sync2 <= SYNC_RST;
      r_state <= '0;
      for (int i = 0; i < N_KEYS; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= key_in;
      r_sync2 <= r_sync1;
      r_state <= r_state ^ w_accept;
      for (int i = 0; i < N_KEYS; i++) begin
        if ((w_level[i] == r_state[i]) || w_accept[i]) r_cnt[i] <= '0;
        else                                           r_cnt[i] <= r_cnt[i] + CW'(1);
      end
    end
  end

`ifdef UAB_BOARD_IO_LED_PWM_EN
  logic [7:0] r_duty, r_pwm_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_duty    <= 8'hFF;
      r_pwm_cnt <= 8'd0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
      if (write && address == 3'd4) r_duty <= writedata[7:0];
    end
  end

  assign w_led_on = r_led & {N_LEDS{r_pwm_cnt < r_duty}};
`else
  assign w_led_on = r_led;
`endif

  // Reads sample the registers before any same-cycle write lands.
  always_comb begin
    w_rdata = '0;
    case (address)
      3'd0: w_rdata[N_LEDS-1:0] = r_led;
      3'd1: w_rdata[N_KEYS-1:0] = r_state;
      3'd2: w_rdata[N_KEYS-1:0] = r_edge;
      3'd3: w_rdata[N_KEYS-1:0] = r_mask;
`ifdef UAB_BOARD_IO_LED_PWM_EN
      3'd4: w_rdata[7:0]        = r_duty;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led      <= LED_RESET_VAL;
      r_led_out  <= LED_RESET_VAL;
      r_mask     <= '0;
      r_edge     <= '0;
      r_irq      <= 1'b0;
      r_readdata <= '0;
      r_rvalid   <= 1'b0;
    end else begin
      if (write && address == 3'd0) r_led  <= writedata[N_LEDS-1:0];
      if (write && address == 3'd3) r_mask <= writedata[N_KEYS-1:0];
      r_edge    <= (r_edge & ~w_w1c) | w_rise;
      r_irq     <= |(r_edge & r_mask);
      r_led_out <= w_led_on;
      r_rvalid  <= read;
      if (read) r_readdata <= w_rdata;
    end
  end

  assign readdata      = r_readdata;
  assign readdatavalid = r_rvalid;
  assign irq           = r_irq;
  assign led_out       = r_led_out;

endmodule
